// File: rtl/dma_read_master_pkg.sv
// Shared constants and types for the DMA read master and its burst calculator.
//   AXI encodings (INCR burst, 4-byte beat size, OKAY response) and the
//   burst limits (256 B per burst, no burst may straddle a 4 KB page).
//   burst_t is the (beats, arlen) pair that the burst calculator produces.
package dma_read_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B         = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
  localparam int         DMA_MAX_BURST_BYTES = 256;
  localparam int         DMA_4K_BOUNDARY     = 32'h1000;
  localparam int         BEAT_BYTES          = 4;

  typedef struct packed {
    logic [6:0] beats;  // beats in the next burst (1..64 while bytes remain)
    logic [7:0] arlen;  // beats - 1
  } burst_t;

endpackage

// File: rtl/dma_read_master_if.sv
// AXI4 read channel bundle (AR + R) between the DMA read master and memory.
//   master modport : drives araddr/arlen/arsize/arburst/arvalid and rready
//   slave modport  : drives arready and rdata/rresp/rlast/rvalid
interface dma_read_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizer shared by the DMA read and write masters.
//   addr_lo   : byte address bits [11:2] (offset within the 4 KB page, in beats)
//   rem_beats : remaining byte count bits [31:2] (remaining length in beats)
//   burst     : beats = min(remaining, 256 B, bytes to page end) / 4, arlen = beats-1
// Working in beat units keeps every operand exactly as wide as it needs to be.
module dma_burst_calc
  import dma_read_master_pkg::*;
(
  input  logic [9:0]  addr_lo,
  input  logic [29:0] rem_beats,
  output burst_t      burst
);
  localparam logic [10:0] MAX_BEATS  = 11'(DMA_MAX_BURST_BYTES / BEAT_BYTES);
  localparam logic [10:0] PAGE_BEATS = 11'(DMA_4K_BOUNDARY / BEAT_BYTES);

  logic [10:0] to_page;
  logic [10:0] lim;
  logic [6:0]  beats;

  always_comb begin
    to_page = PAGE_BEATS - {1'b0, addr_lo};
    lim     = (to_page < MAX_BEATS) ? to_page : MAX_BEATS;
    beats   = (rem_beats < 30'(lim)) ? 7'(rem_beats) : 7'(lim);
  end

  // arlen is meaningless when beats == 0; the FSM never issues an AR then.
  assign burst.beats = beats;
  assign burst.arlen = 8'(beats) - 8'd1;

endmodule

// File: rtl/dma_read_master.sv
// AXI4 read master for the DMA datapath.
//   clk, reset         : clock, asynchronous active-high reset
//   i_start            : start pulse, accepted only while idle
//   i_src_addr         : source byte address (4 B aligned)
//   i_total_len        : bytes to move (bits [1:0] ignored)
//   o_busy             : transfer in progress
//   o_read_done        : all beats pushed; held until the next accepted start
//   o_error            : sticky bad RRESP / RLAST mismatch, cleared on start
//   i_fifo_full        : downstream FIFO full (throttles rready)
//   i_fifo_count       : words in downstream FIFO (gates AR issue)
//   o_fifo_wr_en/wdata : push strobe and data, same cycle as the R handshake
//   m_axi              : AXI read channels (master modport)
// One INCR burst is in flight at a time; an AR is only issued once the FIFO
// has room for the whole burst, so R beats are never refused for long.
module dma_read_master
  import dma_read_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_busy,
  output logic                          o_read_done,
  output logic                          o_error,
  input  logic                          i_fifo_full,
  input  logic [$clog2(FIFO_DEPTH):0]   i_fifo_count,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wdata,
  dma_read_master_if.master             m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [31:0]   rem;
  logic [6:0]    beats_q;
  logic [6:0]    cnt;
  logic          arvalid;
  logic          done;
  logic          err;

  burst_t        burst;
  logic [31:0]   len_al;
  logic [31:0]   space;
  logic [31:0]   bytes_q;
  logic          fits;
  logic          rready;
  logic          r_hs;
  logic          last_beat;

  dma_burst_calc u_calc (
    .addr_lo  (addr[11:2]),
    .rem_beats(rem[31:2]),
    .burst    (burst)
  );

  assign len_al    = i_total_len & ~32'h3;
  assign space     = 32'(FIFO_DEPTH) - 32'(i_fifo_count);
  assign fits      = space >= {25'd0, burst.beats};
  assign bytes_q   = {23'd0, beats_q, 2'b00};
  assign rready    = (state == S_R) && !i_fifo_full;
  assign r_hs      = rready && m_axi.rvalid;
  assign last_beat = (cnt == beats_q - 7'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      rem     <= '0;
      beats_q <= '0;
      cnt     <= '0;
      arvalid <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr <= AW'(i_src_addr);
            rem  <= len_al;
            err  <= 1'b0;
            // A zero-length request completes without touching the bus.
            done <= (len_al == 32'd0);
            if (len_al != 32'd0) state <= S_AR;
          end
        end
        S_AR: begin
          // Once raised, arvalid holds; addr/rem do not move here, so the
          // calculated araddr/arlen stay stable until the handshake.
          if (!arvalid) begin
            if (fits) arvalid <= 1'b1;
          end else if (m_axi.arready) begin
            arvalid <= 1'b0;
            beats_q <= burst.beats;
            cnt     <= '0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            if (m_axi.rresp != AXI_RESP_OKAY) err <= 1'b1;
            // RLAST is only audited; the beat count alone ends the burst.
            if (m_axi.rlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              addr <= addr + AW'(bytes_q);
              rem  <= rem - bytes_q;
              if (rem == bytes_q) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state <= S_AR;
              end
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = (state != S_IDLE);
  assign o_read_done   = done;
  assign o_error       = err;
  assign o_fifo_wr_en  = r_hs;
  assign o_fifo_wdata  = m_axi.rdata;

  assign m_axi.araddr  = addr;
  assign m_axi.arlen   = burst.arlen;
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;

endmodule

// File: tb/tb_dma_read_master.sv
module tb_dma_read_master;
  localparam int AW = 32, DW = 32, DEPTH = 256, CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [31:0]   i_src_addr, i_total_len;
  logic          o_busy, o_read_done, o_error;
  logic          i_fifo_full;
  logic [CW-1:0] i_fifo_count;
  logic          o_fifo_wr_en;
  logic [DW-1:0] o_fifo_wdata;

  dma_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  dma_read_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_src_addr(i_src_addr),
    .i_total_len(i_total_len), .o_busy(o_busy), .o_read_done(o_read_done),
    .o_error(o_error), .i_fifo_full(i_fifo_full), .i_fifo_count(i_fifo_count),
    .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wdata(o_fifo_wdata), .m_axi(axi.master)
  );

  always #5 clk = ~clk;

  // memory contents seen by the slave: a fixed scramble of the byte address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  // ---------------- slave / FIFO-side monitor (own counters) ----------------
  int           s_asrt = 0, s_fail = 0;
  int           beat_total = 0;
  int           rresp_bad = -1, rlast_bad = -1;
  bit           full_mode = 1'b0;
  bit           s_active = 1'b0, r_pend = 1'b0, prev_arv = 1'b0;
  logic [31:0]  s_addr, prev_addr;
  logic [7:0]   prev_len;
  int           s_left;
  logic [31:0]  ar_addr_q[$];
  logic [7:0]   ar_len_q[$];
  logic [31:0]  push_q[$];

  initial begin : slave
    bit r_hs;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; i_fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        axi.arready = ($urandom_range(0, 3) != 0);
        i_fifo_full = full_mode && ($urandom_range(0, 2) == 0);
        if (!r_pend) begin
          if (s_active && $urandom_range(0, 3) != 0) begin
            axi.rvalid = 1'b1;
            axi.rdata  = mem(s_addr);
            axi.rresp  = (beat_total == rresp_bad) ? 2'b10 : 2'b00;
            axi.rlast  = (s_left == 1) ^ (beat_total == rlast_bad);
          end else begin
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
          end
        end
      end
      #1;
      if (reset) begin
        s_active = 1'b0; r_pend = 1'b0; prev_arv = 1'b0;
        axi.rvalid = 1'b0; axi.arready = 1'b0; i_fifo_full = 1'b0;
      end else begin
        if (s_active || o_fifo_wr_en || axi.rready) begin
          s_asrt++;
          if (axi.rready !== (s_active && !i_fifo_full)) begin
            s_fail++;
            $display("FAIL rready_track: rready=%b required %b", axi.rready, s_active && !i_fifo_full);
          end
          s_asrt++;
          if (o_fifo_wr_en !== (axi.rvalid && axi.rready)) begin
            s_fail++;
            $display("FAIL wr_en: wr_en=%b required %b", o_fifo_wr_en, axi.rvalid && axi.rready);
          end
          if (o_fifo_wr_en) begin
            s_asrt++;
            if (o_fifo_wdata !== axi.rdata) begin
              s_fail++;
              $display("FAIL wdata: wdata=%h required %h", o_fifo_wdata, axi.rdata);
            end
            push_q.push_back(o_fifo_wdata);
          end
        end
        if (prev_arv) begin
          s_asrt++;
          if ({axi.arvalid, axi.araddr, axi.arlen} !== {1'b1, prev_addr, prev_len}) begin
            s_fail++;
            $display("FAIL ar_stable: arvalid=%b addr=%h len=%0d required 1 %h %0d",
                     axi.arvalid, axi.araddr, axi.arlen, prev_addr, prev_len);
          end
        end
        r_hs = axi.rvalid && axi.rready;
        if (r_hs) begin
          s_addr = s_addr + 4; s_left--; beat_total++;
          if (s_left == 0) s_active = 1'b0;
        end
        r_pend = axi.rvalid && !r_hs;
        if (axi.arvalid && axi.arready) begin
          s_asrt++;
          if ({s_active, axi.arsize, axi.arburst} !== {1'b0, 3'b010, 2'b01}) begin
            s_fail++;
            $display("FAIL ar_attr: outstanding=%b size=%b burst=%b required 0 010 01",
                     s_active, axi.arsize, axi.arburst);
          end
          ar_addr_q.push_back(axi.araddr);
          ar_len_q.push_back(axi.arlen);
          s_active = 1'b1; s_addr = axi.araddr; s_left = int'(axi.arlen) + 1;
          prev_arv = 1'b0;
        end else begin
          prev_arv = axi.arvalid; prev_addr = axi.araddr; prev_len = axi.arlen;
        end
      end
    end
  end

  // ---------------- reference model and main sequence ----------------
  int          n_asrt = 0, n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];
  logic [31:0] exp_data_q[$];
  int          ar0, p0, nb;
  bit          exp_err;

  task automatic build_model(input logic [31:0] src, input logic [31:0] len);
    longint a = src, rem = len & ~32'h3, b;
    exp_addr_q.delete(); exp_len_q.delete(); exp_data_q.delete();
    while (rem > 0) begin
      b = rem;
      if (b > 256) b = 256;
      if (b > 4096 - (a % 4096)) b = 4096 - (a % 4096);
      exp_addr_q.push_back(32'(a));
      exp_len_q.push_back(8'(b / 4 - 1));
      for (longint i = 0; i < b / 4; i++) exp_data_q.push_back(mem(32'(a + 4 * i)));
      a += b; rem -= b;
    end
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] len, input int rk, input int lk);
    build_model(src, len);
    nb = exp_data_q.size(); ar0 = ar_addr_q.size(); p0 = push_q.size();
    rresp_bad = (rk >= 0) ? beat_total + rk : -1;
    rlast_bad = (lk >= 0) ? beat_total + lk : -1;
    exp_err = (rk >= 0 && rk < nb) || (lk >= 0 && lk < nb);
    i_src_addr = src; i_total_len = len; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_asrt++;
    if ({o_busy, o_read_done} !== {nb != 0, nb == 0}) begin
      n_fail++;
      $display("FAIL start_accept: busy/done=%b%b required %b%b", o_busy, o_read_done, nb != 0, nb == 0);
    end
  endtask

  task automatic finish_xfer(input string name, input bit poke);
    int cyc = 0, bad = 0, first = -1;
    while (!o_read_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 8)  begin i_src_addr = 32'h0009_0000; i_total_len = 32'd64; i_start = 1'b1; end
      if (poke && cyc == 10) i_start = 1'b0;
    end
    n_asrt++;
    if (o_read_done !== 1'b1) begin
      n_fail++; $display("FAIL %s done_timeout: done=%b required 1", name, o_read_done);
    end
    n_asrt++;
    if (ar_addr_q.size() - ar0 !== exp_addr_q.size()) begin
      n_fail++; $display("FAIL %s ar_count: got %0d required %0d", name, ar_addr_q.size() - ar0, exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        n_asrt++;
        if ({ar_addr_q[ar0+i], ar_len_q[ar0+i]} !== {exp_addr_q[i], exp_len_q[i]}) begin
          n_fail++;
          $display("FAIL %s ar[%0d]: addr=%h arlen=%0d required %h %0d", name, i,
                   ar_addr_q[ar0+i], ar_len_q[ar0+i], exp_addr_q[i], exp_len_q[i]);
        end
      end
    end
    n_asrt++;
    if (push_q.size() - p0 !== nb) begin
      n_fail++; $display("FAIL %s push_count: got %0d required %0d", name, push_q.size() - p0, nb);
    end else begin
      for (int i = 0; i < nb; i++)
        if (push_q[p0+i] !== exp_data_q[i]) begin bad++; if (first < 0) first = i; end
      n_asrt++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL %s push_data: %0d bad beats (first %0d) required 0", name, bad, first);
      end
    end
    n_asrt++;
    if ({o_busy, o_error} !== {1'b0, exp_err}) begin
      n_fail++; $display("FAIL %s end_flags: busy/error=%b%b required 0%b", name, o_busy, o_error, exp_err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_asrt++;
    if ({o_busy, o_read_done, o_error, o_fifo_wr_en, axi.arvalid, axi.rready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state: outputs=%b required 000000",
        {o_busy, o_read_done, o_error, o_fifo_wr_en, axi.arvalid, axi.rready});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_asrt++;
    if ({o_busy, o_read_done, axi.arvalid} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy/done/arvalid=%b required 000", {o_busy, o_read_done, axi.arvalid});
    end
  endtask

  task automatic test_single();
    i_fifo_count = '0;
    start_xfer(32'h1000, 32'd64, -1, -1);
    n_asrt++;
    if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL latency_early: arvalid=%b required 0", axi.arvalid); end
    @(negedge clk);
    n_asrt++;
    if (axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL latency: arvalid=%b required 1", axi.arvalid); end
    finish_xfer("single", 1'b0);
  endtask

  task automatic test_fifo_space();
    i_fifo_count = CW'(200);
    start_xfer(32'h4000, 32'd256, -1, -1);
    for (int i = 0; i < 25; i++) begin
      if (i == 20) i_fifo_count = CW'(193);
      @(negedge clk);
      n_asrt++;
      if (axi.arvalid !== 1'b0) begin
        n_fail++; $display("FAIL fifo_space_hold: arvalid=%b count=%0d required 0", axi.arvalid, i_fifo_count);
      end
    end
    i_fifo_count = CW'(192);
    @(negedge clk);
    n_asrt++;
    if (axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL fifo_space_release: arvalid=%b required 1", axi.arvalid); end
    finish_xfer("fifo_space", 1'b0);
    i_fifo_count = '0;
  endtask

  task automatic test_len0();
    start_xfer(32'h8000, 32'd0, -1, -1);
    finish_xfer("len0", 1'b0);
    start_xfer(32'h8000, 32'd3, -1, -1);
    repeat (6) @(negedge clk);
    finish_xfer("len3", 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    start_xfer(32'h2000, 32'd1024, -1, -1);
    while (push_q.size() < p0 + 20 && cyc < 3000) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    #1;
    n_asrt++;
    if ({o_busy, o_read_done, o_error, o_fifo_wr_en, axi.arvalid, axi.rready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid: outputs=%b required 000000",
        {o_busy, o_read_done, o_error, o_fifo_wr_en, axi.arvalid, axi.rready});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_xfer(32'h3000, 32'd16, -1, -1);
    finish_xfer("after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] src, len;
    int rk, lk;
    for (int t = 0; t < 12; t++) begin
      src = 32'h0001_0000 + ($urandom_range(0, 32'h3FFF) & ~32'h3);
      len = $urandom_range(0, 1500);
      rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 400)) : -1;
      lk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 400)) : -1;
      full_mode = $urandom_range(0, 1);
      i_fifo_count = CW'($urandom_range(0, 192));
      start_xfer(src, len, rk, lk);
      finish_xfer("random", 1'b0);
    end
    full_mode = 1'b0; i_fifo_count = '0;
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_src_addr = '0; i_total_len = '0; i_fifo_count = '0;
    test_reset();
    test_single();
    start_xfer(32'h0FF0, 32'd64, -1, -1);  finish_xfer("split_4k", 1'b0);
    start_xfer(32'h2000, 32'd1024, -1, -1); finish_xfer("multi_burst", 1'b0);
    test_fifo_space();
    full_mode = 1'b1;
    start_xfer(32'h5000, 32'd512, -1, -1); finish_xfer("fifo_full", 1'b0);
    full_mode = 1'b0;
    start_xfer(32'h6000, 32'd128, 5, -1);  finish_xfer("rresp_err", 1'b0);
    start_xfer(32'h6100, 32'd32, -1, -1);  finish_xfer("err_clear", 1'b0);
    start_xfer(32'h7000, 32'd64, -1, 7);   finish_xfer("rlast_err", 1'b0);
    start_xfer(32'h7FC0, 32'd64, -1, 15);  finish_xfer("rlast_drop", 1'b0);
    start_xfer(32'hA000, 32'd300, -1, -1); finish_xfer("busy_ignore", 1'b1);
    test_len0();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    n_asrt += s_asrt;
    n_fail += s_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
